// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86 encodings: icodes, status codes, register sentinel, the layout
// of the F->D pipeline register and its bubble value.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

  // Instruction codes (high nibble of the opcode byte)
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;
  localparam logic [3:0] I_IADDL  = 4'hC;

  // Pipeline status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // "No register" sentinel
  localparam logic [3:0] RNONE = 4'hF;

  // F->D pipeline register contents
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] valc;
    logic [31:0] valp;
  } d_reg_t;

  // Bubble loaded into D on reset or on a bubble request
  localparam d_reg_t D_BUBBLE = '{
    stat:  S_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  32'h0,
    valp:  32'h0
  };

  // True for jumps and calls, whose next PC is the embedded constant
  function automatic logic predicts_valc(input logic [3:0] icode);
    return (icode == I_JXX) || (icode == I_CALL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/y86_fetch_split.sv
// ---------------------------------------------------------------------------
// y86_fetch_split
// Combinational instruction splitter: decodes the 48-bit instruction window
// at f_pc into icode/ifun/registers/constant, next sequential PC and status.
// Optional feature macro: Y86_IADDL_EN (accept icode C, IADDL).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module y86_fetch_split
  import y86_pkg::*;
#(
  parameter int IMEM_AW = 11
) (
  input  logic [47:0] inst,
  input  logic [31:0] f_pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [31:0] valc,
  output logic [31:0] valp,
  output logic [2:0]  stat
);

  logic imem_error;
  logic instr_valid;
  logic need_regids;
  logic need_valc;

  // Any address bit at or above the memory width is out of range
  generate
    if (IMEM_AW < 32) begin : g_range_chk
      assign imem_error = |f_pc[31:IMEM_AW];
    end else begin : g_full_range
      assign imem_error = 1'b0;
    end
  endgenerate

  // Field split, instruction classification, constant extraction and status
  always_comb begin
    icode       = imem_error ? I_NOP : inst[47:44];
    ifun        = imem_error ? 4'h0  : inst[43:40];
    instr_valid = 1'b0;
    need_regids = 1'b0;
    need_valc   = 1'b0;

    case (icode)
      I_HALT, I_NOP, I_RET: begin
        instr_valid = 1'b1;
      end
      I_RRMOVL, I_OPL, I_PUSHL, I_POPL: begin
        instr_valid = 1'b1;
        need_regids = 1'b1;
      end
      I_IRMOVL, I_RMMOVL, I_MRMOVL: begin
        instr_valid = 1'b1;
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      I_JXX, I_CALL: begin
        instr_valid = 1'b1;
        need_valc   = 1'b1;
      end
`ifdef Y86_IADDL_EN
      I_IADDL: begin
        instr_valid = 1'b1;
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
`endif
      default: begin
        instr_valid = 1'b0;
      end
    endcase

    ra = need_regids ? inst[39:36] : RNONE;
    rb = need_regids ? inst[35:32] : RNONE;

    // Little-endian constant starts right after the opcode or register byte
    if (!need_valc) begin
      valc = 32'h0;
    end else if (need_regids) begin
      valc = {inst[7:0], inst[15:8], inst[23:16], inst[31:24]};
    end else begin
      valc = {inst[15:8], inst[23:16], inst[31:24], inst[39:32]};
    end

    valp = f_pc + 32'd1 + {31'd0, need_regids} + (need_valc ? 32'd4 : 32'd0);

    if (imem_error) begin
      stat = S_ADR;
    end else if (!instr_valid) begin
      stat = S_INS;
    end else if (icode == I_HALT) begin
      stat = S_HLT;
    end else begin
      stat = S_AOK;
    end
  end

endmodule

`default_nettype wire

// File: rtl/y86_fetch.sv
// ---------------------------------------------------------------------------
// y86_fetch
// Y86 pipeline fetch stage: PC selection, next-PC prediction, predicted-PC
// register and the F->D pipeline register with stall/bubble control.
// Optional feature macro: Y86_IADDL_EN (handled in y86_fetch_split).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module y86_fetch
  import y86_pkg::*;
#(
  parameter int          IMEM_AW  = 11,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] inst,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [31:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [31:0] W_valM,
  output logic [31:0] f_pc,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [31:0] D_valC,
  output logic [31:0] D_valP
);

  logic [31:0] F_predPC;
  logic [31:0] pred_pc;
  d_reg_t      dec;
  d_reg_t      d_q;

  y86_fetch_split #(
    .IMEM_AW (IMEM_AW)
  ) u_split (
    .inst  (inst),
    .f_pc  (f_pc),
    .icode (dec.icode),
    .ifun  (dec.ifun),
    .ra    (dec.ra),
    .rb    (dec.rb),
    .valc  (dec.valc),
    .valp  (dec.valp),
    .stat  (dec.stat)
  );

  // Fetch address: mispredicted branch first, then return address, else prediction
  always_comb begin
    if ((M_icode == I_JXX) && !M_Cnd) begin
      f_pc = M_valA;
    end else if (W_icode == I_RET) begin
      f_pc = W_valM;
    end else begin
      f_pc = F_predPC;
    end
  end

  // Jumps and calls are predicted taken; everything else falls through
  always_comb begin
    pred_pc = predicts_valc(dec.icode) ? dec.valc : dec.valp;
  end

  // Predicted-PC register, frozen by F_stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_predPC <= RESET_PC;
    end else if (!F_stall) begin
      F_predPC <= pred_pc;
    end
  end

  // F->D register: stall holds (and overrides bubble), bubble inserts a NOP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q <= D_BUBBLE;
    end else if (D_stall) begin
      d_q <= d_q;
    end else if (D_bubble) begin
      d_q <= D_BUBBLE;
    end else begin
      d_q <= dec;
    end
  end

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.valc;
  assign D_valP  = d_q.valp;

endmodule

`default_nettype wire

// File: tb/tb_y86_fetch.sv
// ---------------------------------------------------------------------------
// tb_y86_fetch
// Directed self-checking bench for the Y86 fetch stage.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_y86_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] inst;
  logic        F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [31:0] M_valA;
  logic [3:0]  W_icode;
  logic [31:0] W_valM;
  logic [31:0] f_pc;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [31:0] D_valC, D_valP;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [47:0] NOP_W    = 48'h10_00_00_00_00_00;
  localparam logic [47:0] IRMOV_W  = 48'h30_F4_10_00_00_00;
  localparam logic [47:0] JMP_W    = 48'h70_00_12_00_00_00;
  localparam logic [47:0] IADDL_W  = 48'hC0_F3_05_00_00_00;

`ifdef Y86_IADDL_EN
  localparam logic [31:0] E_C_STAT = 32'd1;
  localparam logic [31:0] E_C_VALP = 32'h26;
  localparam logic [31:0] E_C_RB   = 32'h3;
  localparam logic [31:0] E_C_VALC = 32'h5;
`else
  localparam logic [31:0] E_C_STAT = 32'd4;
  localparam logic [31:0] E_C_VALP = 32'h21;
  localparam logic [31:0] E_C_RB   = 32'hF;
  localparam logic [31:0] E_C_VALC = 32'h0;
`endif

  y86_fetch #(
    .IMEM_AW  (11),
    .RESET_PC (32'h0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .inst     (inst),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .D_bubble (D_bubble),
    .M_icode  (M_icode),
    .M_Cnd    (M_Cnd),
    .M_valA   (M_valA),
    .W_icode  (W_icode),
    .W_valM   (W_valM),
    .f_pc     (f_pc),
    .D_stat   (D_stat),
    .D_icode  (D_icode),
    .D_ifun   (D_ifun),
    .D_rA     (D_rA),
    .D_rB     (D_rB),
    .D_valC   (D_valC),
    .D_valP   (D_valP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; inst = NOP_W;
    F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    M_icode = 4'h1; M_Cnd = 1'b1; M_valA = 32'h0;
    W_icode = 4'h1; W_valM = 32'h0;

    // Reset state
    #3;
    chk("rst_fpc",   f_pc,    32'h0);
    chk("rst_stat",  D_stat,  32'd1);
    chk("rst_icode", D_icode, 32'd1);
    chk("rst_ifun",  D_ifun,  32'd0);
    chk("rst_ra",    D_rA,    32'hF);
    chk("rst_rb",    D_rB,    32'hF);
    chk("rst_valc",  D_valC,  32'h0);
    chk("rst_valp",  D_valP,  32'h0);
    reset = 1'b0;

    // First edge: NOP at 0 advances the prediction to 1
    step();
    chk("nop_fpc",   f_pc,    32'h1);
    chk("nop_icode", D_icode, 32'd1);
    chk("nop_valp",  D_valP,  32'h1);

    // Redirect to 0x10, fetch irmovl $16,%esp
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 32'h10; inst = IRMOV_W;
    #1;
    chk("misp_fpc", f_pc, 32'h10);
    step();
    M_icode = 4'h1;
    #1;
    chk("irm_fpc",   f_pc,    32'h16);
    chk("irm_icode", D_icode, 32'd3);
    chk("irm_ra",    D_rA,    32'hF);
    chk("irm_rb",    D_rB,    32'h4);
    chk("irm_valc",  D_valC,  32'h10);
    chk("irm_valp",  D_valP,  32'h16);
    chk("irm_stat",  D_stat,  32'd1);

    // jmp 0x1200 at 0x16: predicted taken
    inst = JMP_W;
    step();
    chk("jmp_fpc",   f_pc,    32'h1200);
    chk("jmp_icode", D_icode, 32'd7);
    chk("jmp_valc",  D_valC,  32'h1200);
    chk("jmp_valp",  D_valP,  32'h1B);
    chk("jmp_rb",    D_rB,    32'hF);

    // Mispredict, taken-branch, and RET-vs-mispredict priority
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 32'h5; #1;
    chk("misp5_fpc", f_pc, 32'h5);
    M_Cnd = 1'b1; #1;
    chk("taken_fpc", f_pc, 32'h1200);
    M_Cnd = 1'b0; M_valA = 32'h8; W_icode = 4'h9; W_valM = 32'h40; #1;
    chk("misp_over_ret", f_pc, 32'h8);
    M_icode = 4'h1; #1;
    chk("ret_fpc", f_pc, 32'h40);
    W_icode = 4'h1;

    // Out-of-range fetch at 0x800
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 32'h800; inst = IRMOV_W;
    #1;
    chk("adr_fpc", f_pc, 32'h800);
    step();
    chk("adr_stat",  D_stat,  32'd3);
    chk("adr_icode", D_icode, 32'd1);
    chk("adr_ifun",  D_ifun,  32'd0);
    chk("adr_ra",    D_rA,    32'hF);
    chk("adr_valp",  D_valP,  32'h801);

    // valP wraps at the top of the address space
    M_valA = 32'hFFFF_FFFF;
    step();
    chk("wrap_stat", D_stat, 32'd3);
    chk("wrap_valp", D_valP, 32'h0);

    // icode C at 0x20
    M_valA = 32'h20; inst = IADDL_W;
    step();
    M_icode = 4'h1; inst = NOP_W;
    #1;
    chk("c_stat",  D_stat,  E_C_STAT);
    chk("c_icode", D_icode, 32'hC);
    chk("c_valp",  D_valP,  E_C_VALP);
    chk("c_rb",    D_rB,    E_C_RB);
    chk("c_valc",  D_valC,  E_C_VALC);
    chk("c_fpc",   f_pc,    E_C_VALP);

    // Stall and bubble together for two cycles: everything holds
    F_stall = 1'b1; D_stall = 1'b1; D_bubble = 1'b1;
    step();
    step();
    chk("stb_icode", D_icode, 32'hC);
    chk("stb_valp",  D_valP,  E_C_VALP);
    chk("stb_fpc",   f_pc,    E_C_VALP);

    // Bubble alone
    F_stall = 1'b0; D_stall = 1'b0;
    step();
    chk("bub_icode", D_icode, 32'd1);
    chk("bub_ra",    D_rA,    32'hF);
    chk("bub_stat",  D_stat,  32'd1);
    chk("bub_valp",  D_valP,  32'h0);
    chk("bub_fpc",   f_pc,    E_C_VALP + 32'd1);

    // F_stall alone: fetch address held, D keeps loading
    D_bubble = 1'b0; F_stall = 1'b1;
    step();
    chk("fst_fpc",   f_pc,    E_C_VALP + 32'd1);
    chk("fst_icode", D_icode, 32'd1);
    chk("fst_valp",  D_valP,  E_C_VALP + 32'd2);
    F_stall = 1'b0;

    // Asynchronous mid-operation reset
    #2;
    reset = 1'b1;
    #1;
    chk("arst_fpc",   f_pc,    32'h0);
    chk("arst_valp",  D_valP,  32'h0);
    chk("arst_icode", D_icode, 32'd1);
    reset = 1'b0;
    step();
    chk("post_rst_fpc", f_pc, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
